// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: controller states,
// per-street light encodings, default interval durations and the timer width.
// The optional programmable-timing feature is enabled by defining PROG_TIMING_EN.
package traffic_pkg;

   typedef enum logic [2:0] {
      MG1    = 3'd0,
      MG2    = 3'd1,
      MG_EXT = 3'd2,
      MY     = 3'd3,
      WALK   = 3'd4,
      SG     = 3'd5,
      SG_EXT = 3'd6,
      SY     = 3'd7
   } state_t;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   localparam int DEF_T_BASE = 6;
   localparam int DEF_T_EXT  = 3;
   localparam int DEF_T_YEL  = 2;
   localparam int DEF_CNT_W  = 4;

   // Main street shows green through all main-green phases, yellow in MY,
   // and red whenever the side street or pedestrians own the crossing.
   function automatic logic [2:0] main_lights(input state_t s);
      case (s)
         MG1, MG2, MG_EXT: return GRN;
         MY:               return YEL;
         default:          return RED;
      endcase
   endfunction

   // Side street is green only in its own green phases, yellow in SY.
   function automatic logic [2:0] side_lights(input state_t s);
      case (s)
         SG, SG_EXT: return GRN;
         SY:         return YEL;
         default:    return RED;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the traffic light controller and its surroundings
// (clock divider tick, sensor, walk register and the lamp drivers).
// Programming signals exist only when PROG_TIMING_EN is defined.
interface traffic_light_fsm_if;

   logic       one_hz_enable;
   logic       sensor_sync;
   logic       wr;
   logic       wr_reset;
   logic [2:0] lights_main;
   logic [2:0] lights_side;
   logic       walk_lamp;
`ifdef PROG_TIMING_EN
   logic       prog_sync;
   logic [1:0] time_param_selector;
   logic [3:0] time_value;
`endif

   modport master (
      output one_hz_enable,
      output sensor_sync,
      output wr,
`ifdef PROG_TIMING_EN
      output prog_sync,
      output time_param_selector,
      output time_value,
`endif
      input  wr_reset,
      input  lights_main,
      input  lights_side,
      input  walk_lamp
   );

   modport slave (
      input  one_hz_enable,
      input  sensor_sync,
      input  wr,
`ifdef PROG_TIMING_EN
      input  prog_sync,
      input  time_param_selector,
      input  time_value,
`endif
      output wr_reset,
      output lights_main,
      output lights_side,
      output walk_lamp
   );

endinterface

// File: rtl/interval_timer.sv
// Down-counting interval timer. The controller loads the new state's
// duration on every state entry; the count steps down once per 1 Hz tick
// and "expired" flags the tick on which the final second is consumed.
module interval_timer #(
   parameter int CNT_W       = 4,
   parameter int RESET_VALUE = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   // Load has priority so a state entry always starts a fresh interval;
   // the count never goes below one because expiry triggers a reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= CNT_W'(RESET_VALUE);
      end else if (load) begin
         count <= load_value;
      end else if (tick && (count > CNT_W'(1))) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired = tick && (count == CNT_W'(1));

endmodule

// File: rtl/traffic_light_fsm.sv
// Main traffic light controller: sequences main/side street lights and the
// walk lamp, consumes the latched walk request and pulses wr_reset on entry
// to the walk interval. Defining PROG_TIMING_EN adds run-time programmable
// durations; otherwise the durations are the fixed parameters.
module traffic_light_fsm
   import traffic_pkg::*;
#(
   parameter int T_BASE = DEF_T_BASE,
   parameter int T_EXT  = DEF_T_EXT,
   parameter int T_YEL  = DEF_T_YEL,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic                clk,
   input logic                rst,
   traffic_light_fsm_if.slave bus
);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] dur_base_next;
   logic [CNT_W-1:0] dur_ext_next;
   logic [CNT_W-1:0] dur_yel_next;
   logic             prog_force;
   logic             timer_load;
   logic [CNT_W-1:0] timer_load_value;
   logic             timer_expired;
   logic [2:0]       lights_main_q;
   logic [2:0]       lights_side_q;
   logic             walk_lamp_q;
   logic             wr_reset_q;

`ifdef PROG_TIMING_EN
   logic [CNT_W-1:0] dur_base;
   logic [CNT_W-1:0] dur_ext;
   logic [CNT_W-1:0] dur_yel;
   logic [CNT_W-1:0] prog_value;

   assign prog_value = (bus.time_value == 4'd0) ? CNT_W'(1) : CNT_W'(bus.time_value);
   assign prog_force = bus.prog_sync;

   // Value each duration register holds after this edge, so a counter
   // reload in the same cycle already sees the freshly programmed duration.
   always_comb begin
      dur_base_next = dur_base;
      dur_ext_next  = dur_ext;
      dur_yel_next  = dur_yel;
      if (bus.prog_sync) begin
         case (bus.time_param_selector)
            2'b00:   dur_base_next = prog_value;
            2'b01:   dur_ext_next  = prog_value;
            2'b10:   dur_yel_next  = prog_value;
            default: ;
         endcase
      end
   end

   // Programmable duration registers, restored to the build defaults on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dur_base <= CNT_W'(T_BASE);
         dur_ext  <= CNT_W'(T_EXT);
         dur_yel  <= CNT_W'(T_YEL);
      end else begin
         dur_base <= dur_base_next;
         dur_ext  <= dur_ext_next;
         dur_yel  <= dur_yel_next;
      end
   end
`else
   assign dur_base_next = CNT_W'(T_BASE);
   assign dur_ext_next  = CNT_W'(T_EXT);
   assign dur_yel_next  = CNT_W'(T_YEL);
   assign prog_force    = 1'b0;
`endif

   interval_timer #(
      .CNT_W       (CNT_W),
      .RESET_VALUE (T_BASE)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .tick       (bus.one_hz_enable),
      .load       (timer_load),
      .load_value (timer_load_value),
      .expired    (timer_expired)
   );

   // Next-state decision: sensor and walk request only matter on the exit
   // edge of the deciding state; every transition reloads the timer.
   always_comb begin
      next_state       = state;
      timer_load       = 1'b0;
      timer_load_value = dur_base_next;
      if (prog_force) begin
         next_state = MG1;
         timer_load = 1'b1;
      end else if (timer_expired) begin
         timer_load = 1'b1;
         case (state)
            MG1:     next_state = bus.sensor_sync ? MG_EXT : MG2;
            MG2:     next_state = MY;
            MG_EXT:  next_state = MY;
            MY:      next_state = bus.wr ? WALK : SG;
            WALK:    next_state = SG;
            SG:      next_state = bus.sensor_sync ? SG_EXT : SY;
            SG_EXT:  next_state = SY;
            SY:      next_state = MG1;
            default: next_state = MG1;
         endcase
         case (next_state)
            MG_EXT, WALK, SG_EXT: timer_load_value = dur_ext_next;
            MY, SY:               timer_load_value = dur_yel_next;
            default:              timer_load_value = dur_base_next;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MG1;
      end else begin
         state <= next_state;
      end
   end

   // Lamp outputs are registered from the upcoming state so they change on
   // the same edge as the state, with no input-to-output combinational path;
   // wr_reset fires only on the edge that enters WALK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lights_main_q <= GRN;
         lights_side_q <= RED;
         walk_lamp_q   <= 1'b0;
         wr_reset_q    <= 1'b0;
      end else begin
         lights_main_q <= main_lights(next_state);
         lights_side_q <= side_lights(next_state);
         walk_lamp_q   <= (next_state == WALK);
         wr_reset_q    <= (next_state == WALK) && (state != WALK);
      end
   end

   assign bus.lights_main = lights_main_q;
   assign bus.lights_side = lights_side_q;
   assign bus.walk_lamp   = walk_lamp_q;
   assign bus.wr_reset    = wr_reset_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: random stimulus drives a
// phase/seconds-remaining reference model that queues the expected lamps for
// every clock; a monitor pops and compares after each rising edge.
module tb_traffic_light_fsm;

   localparam int P_MG1   = 0;
   localparam int P_MG2   = 1;
   localparam int P_MGEXT = 2;
   localparam int P_MY    = 3;
   localparam int P_WALK  = 4;
   localparam int P_SG    = 5;
   localparam int P_SGEXT = 6;
   localparam int P_SY    = 7;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   typedef struct packed {
      logic [2:0] mainLights;
      logic [2:0] sideLights;
      logic       walk;
      logic       wrReset;
   } expect_t;

   int checks = 0;
   int errors = 0;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic tick   = 1'b0;
   logic sensor = 1'b0;
   logic wrIn   = 1'b0;
`ifdef PROG_TIMING_EN
   logic       progSync = 1'b0;
   logic [1:0] progSel  = 2'b00;
   logic [3:0] progVal  = 4'd0;
`endif

   int phase;
   int remaining;
   int durBase;
   int durExt;
   int durYel;
   int tickPhase = 0;
   expect_t expQ[$];

   traffic_light_fsm_if bus ();

   assign bus.one_hz_enable = tick;
   assign bus.sensor_sync   = sensor;
   assign bus.wr            = wrIn;
`ifdef PROG_TIMING_EN
   assign bus.prog_sync           = progSync;
   assign bus.time_param_selector = progSel;
   assign bus.time_value          = progVal;
`endif

   traffic_light_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic int durOf(input int p);
      if (p == P_MG1 || p == P_MG2 || p == P_SG) return durBase;
      if (p == P_MY || p == P_SY) return durYel;
      return durExt;
   endfunction

   function automatic int nextPhase(input int p, input logic s, input logic w);
      case (p)
         P_MG1:   return s ? P_MGEXT : P_MG2;
         P_MG2:   return P_MY;
         P_MGEXT: return P_MY;
         P_MY:    return w ? P_WALK : P_SG;
         P_WALK:  return P_SG;
         P_SG:    return s ? P_SGEXT : P_SY;
         P_SGEXT: return P_SY;
         default: return P_MG1;
      endcase
   endfunction

   function automatic expect_t makeExpect(input int p, input logic entered);
      expect_t e;
      e.mainLights = RED;
      e.sideLights = RED;
      if (p == P_MG1 || p == P_MG2 || p == P_MGEXT) e.mainLights = GRN;
      if (p == P_MY) e.mainLights = YEL;
      if (p == P_SG || p == P_SGEXT) e.sideLights = GRN;
      if (p == P_SY) e.sideLights = YEL;
      e.walk    = (p == P_WALK);
      e.wrReset = entered;
      return e;
   endfunction

   function automatic void modelReset();
      durBase   = 6;
      durExt    = 3;
      durYel    = 2;
      phase     = P_MG1;
      remaining = durBase;
   endfunction

   // Advance the model by one clock using the inputs the bench just drove.
   function automatic void modelStep();
      logic entered = 1'b0;
`ifdef PROG_TIMING_EN
      if (progSync) begin
         case (progSel)
            2'b00:   durBase = (progVal == 0) ? 1 : int'(progVal);
            2'b01:   durExt  = (progVal == 0) ? 1 : int'(progVal);
            2'b10:   durYel  = (progVal == 0) ? 1 : int'(progVal);
            default: ;
         endcase
         phase     = P_MG1;
         remaining = durBase;
         expQ.push_back(makeExpect(phase, 1'b0));
         return;
      end
`endif
      if (tick) begin
         if (remaining == 1) begin
            phase     = nextPhase(phase, sensor, wrIn);
            remaining = durOf(phase);
            entered   = (phase == P_WALK);
         end else begin
            remaining = remaining - 1;
         end
      end
      expQ.push_back(makeExpect(phase, entered));
   endfunction

   task automatic checkOutput(input expect_t e, input string tag);
      checks++;
      if (bus.lights_main !== e.mainLights) begin
         errors++;
         $display("[TB] FAIL %s lights_main at %0t: got %b want %b", tag, $time, bus.lights_main, e.mainLights);
      end
      checks++;
      if (bus.lights_side !== e.sideLights) begin
         errors++;
         $display("[TB] FAIL %s lights_side at %0t: got %b want %b", tag, $time, bus.lights_side, e.sideLights);
      end
      checks++;
      if (bus.walk_lamp !== e.walk) begin
         errors++;
         $display("[TB] FAIL %s walk_lamp at %0t: got %b want %b", tag, $time, bus.walk_lamp, e.walk);
      end
      checks++;
      if (bus.wr_reset !== e.wrReset) begin
         errors++;
         $display("[TB] FAIL %s wr_reset at %0t: got %b want %b", tag, $time, bus.wr_reset, e.wrReset);
      end
   endtask

   task automatic applyStimulus(input int cycles, input int tickPeriod, input int sensorPct, input int wrPct);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
`ifdef PROG_TIMING_EN
         progSync = 1'b0;
`endif
         tick   = ((tickPhase % tickPeriod) == 0);
         tickPhase++;
         sensor = ($urandom_range(0, 99) < sensorPct);
         wrIn   = ($urandom_range(0, 99) < wrPct);
         modelStep();
      end
   endtask

   task automatic resetDut();
      expect_t e;
      @(negedge clk);
      tick   = 1'b0;
      sensor = 1'b0;
      wrIn   = 1'b0;
`ifdef PROG_TIMING_EN
      progSync = 1'b0;
`endif
      #2 rst = 1'b1;
      #1;
      e = '{mainLights: GRN, sideLights: RED, walk: 1'b0, wrReset: 1'b0};
      checkOutput(e, "async_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      modelReset();
   endtask

`ifdef PROG_TIMING_EN
   task automatic progWrite(input logic [1:0] sel, input logic [3:0] val);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         progSync = 1'b1;
         progSel  = sel;
         progVal  = val;
         tick     = ((tickPhase % 2) == 0);
         tickPhase++;
         sensor   = $urandom_range(0, 1) == 1;
         wrIn     = $urandom_range(0, 1) == 1;
         modelStep();
      end
   endtask
`endif

   // Monitor: one expected record per clock, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) checkOutput(expQ.pop_front(), "scoreboard");
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      expect_t e;
      int guard;
      modelReset();
      repeat (2) @(negedge clk);
      e = '{mainLights: GRN, sideLights: RED, walk: 1'b0, wrReset: 1'b0};
      checkOutput(e, "power_on_reset");
      rst = 1'b0;

      $display("[TB] plain cycle, tick every 4 clocks");
      applyStimulus(100, 4, 0, 0);
      $display("[TB] sensor held high");
      applyStimulus(120, 4, 100, 0);
      $display("[TB] random sensor and walk requests");
      applyStimulus(300, 4, 40, 20);
      $display("[TB] tick held high");
      applyStimulus(400, 1, 30, 30);

      $display("[TB] reset in the middle of SG");
      guard = 0;
      while (!(phase == P_SG && remaining == 3) && guard < 3000) begin
         applyStimulus(1, 2, 20, 0);
         guard++;
      end
      checks++;
      if (guard >= 3000) begin
         errors++;
         $display("[TB] FAIL reach_mid_sg: got no SG after %0d cycles want SG reached", guard);
      end
      resetDut();
      applyStimulus(60, 4, 0, 0);

      $display("[TB] random tick periods");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(300, int'($urandom_range(1, 5)), int'($urandom_range(0, 100)), int'($urandom_range(0, 60)));
      end

`ifdef PROG_TIMING_EN
      $display("[TB] programmable timing");
      progWrite(2'b10, 4'd0);
      applyStimulus(200, 2, 30, 30);
      progWrite(2'b00, 4'd9);
      applyStimulus(300, 2, 30, 30);
      progWrite(2'b11, 4'd5);
      applyStimulus(150, 1, 30, 30);
      progWrite(2'b01, 4'd1);
      applyStimulus(150, 1, 50, 50);
      resetDut();
      applyStimulus(150, 1, 30, 30);
`endif

      repeat (3) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Main controller of the traffic light design.
- Consumes the latched pedestrian request WR from WalkRegister.
- Returns WR_Reset to clear that request once the walk interval is served.
- Sequences main and side street lights and the walk lamp, using an internal interval timer driven by a 1 Hz enable from the clock divider.

Parameters:
- T_BASE, 6, base green duration in seconds (1..15)
- T_EXT, 3, green extension when Sensor_Sync is set; also walk duration in seconds (1..15)
- T_YEL, 2, yellow duration in seconds (1..15)
- CNT_W, 4, interval counter width

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- OneHz_Enable  in  1  one-Clk-wide tick, once per second
- Sensor_Sync  in  1  synchronized side-street vehicle sensor
- WR  in  1  pending walk request from WalkRegister
- WR_Reset  out  1  one-cycle pulse clearing WalkRegister
- LightsMain  out  3  {R,Y,G} main street, one-hot
- LightsSide  out  3  {R,Y,G} side street, one-hot
- WalkLamp  out  1  pedestrian walk indicator

Behaviour:
- States and lights:
  - MG1: main G, side R, duration T_BASE.
  - MG2: main G, side R, duration T_BASE.
  - MG_EXT: main G, side R, duration T_EXT.
  - MY: main Y, side R, duration T_YEL.
  - WALK: both R, WalkLamp=1, duration T_EXT.
  - SG: main R, side G, duration T_BASE.
  - SG_EXT: main R, side G, duration T_EXT.
  - SY: main R, side Y, duration T_YEL.
- Transitions:
  - MG1 -> MG_EXT if Sensor_Sync, else MG2.
  - MG2 -> MY.
  - MG_EXT -> MY.
  - MY -> WALK if WR, else SG.
  - WALK -> SG.
  - SG -> SG_EXT if Sensor_Sync, else SY.
  - SG_EXT -> SY.
  - SY -> MG1.
- Timer:
  - Counter is loaded with the new state's duration on every state entry.
  - It decrements only on OneHz_Enable.
  - The state transition occurs on the Clk edge where OneHz_Enable=1 and counter==1, so each state lasts exactly N ticks.
- Sampling: Sensor_Sync and WR are sampled only on the exit edge of the deciding state. Changes at any other time are ignored for that decision.
- WR_Reset:
  - High for exactly the first Clk cycle in which state==WALK.
  - Never asserted otherwise.
  - A WR arriving during WALK or later is served at the next MY exit.
- Outputs are registered, with no combinational path from inputs to outputs.
- Lights are always one-hot per street. Main and side are never both non-red.
- Reset, asynchronous, allowed at any point including mid-interval:
  - state=MG1, counter=T_BASE.
  - LightsMain=001, LightsSide=100.
  - WalkLamp=0, WR_Reset=0.
- OneHz_Enable held high continuously: one decrement per Clk. This mode is legal for simulation speed-up.

Optional Feature:
- PROG_TIMING_EN defined:
  - Adds ports Prog_Sync (in 1), Time_Param_Selector (in 2: 00=base, 01=ext, 10=yel, 11=ignored) and Time_Value (in 4).
  - While Prog_Sync=1, the selected duration register loads Time_Value. A value of 0 is stored as 1.
  - The FSM is forced to MG1 with the counter reloaded.
  - Duration registers reset to the parameter defaults.
- Not defined: the ports are absent and durations are fixed parameters.

Decomposition:
- Package traffic_pkg: state enum, light encodings (RED=100, YEL=010, GRN=001), default durations, CNT_W.
- Sub-module interval_timer: load value, load strobe, OneHz_Enable; outputs expired (counter==1 && tick).

Test Plan:
- Reset mid-SG, then release -> MG1, LightsMain=001, LightsSide=100, WalkLamp=0; first transition after 6 ticks.
- No sensor, no WR, tick every 4 Clk:
  - MG1 6 ticks, MG2 6 ticks, MY 2 ticks, SG 6 ticks, SY 2 ticks, then back to MG1.
- Sensor_Sync=1 at MG1 exit -> MG_EXT 3 ticks, then MY. Sensor dropped mid-MG_EXT has no effect.
- WR=1 during MG2 -> after MY: WALK with LightsMain=LightsSide=100 and WalkLamp=1 for 3 ticks; WR_Reset high exactly 1 Clk on entry; then SG.
- WR=1 asserted during WALK (after the WR_Reset pulse) -> no repeat walk this cycle; WALK taken at the following MY exit.
- PROG_TIMING_EN: Prog_Sync=1, selector 10, value 0 -> FSM in MG1; yellow lasts 1 tick; selector 00, value 9 -> MG1 lasts 9 ticks.
